// File: rtl/median5_column_feeder.sv
// Four-line raster buffer feeding the 5x5 median column sorter.
// Every accepted pixel from row 4 onward emits the vertical column ending at it, one cycle later.
module median5_column_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         done_i,
  input  logic [DATA_WIDTH-1:0]        pixel_i,
  output logic [DATA_WIDTH-1:0]        S1,
  output logic [DATA_WIDTH-1:0]        S2,
  output logic [DATA_WIDTH-1:0]        S3,
  output logic [DATA_WIDTH-1:0]        S4,
  output logic [DATA_WIDTH-1:0]        S5,
  output logic [$clog2(IMG_WIDTH)-1:0] col_o,
  output logic                         done_o,
  output logic                         frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_s1, r_s2, r_s3, r_s4, r_s5;
  logic [CW-1:0]         r_col_o;
  logic                  r_done;
  logic                  r_frame_done;

  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_row_valid;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_lb_rd [4];

  assign w_last_col  = (r_col == CW'(IMG_WIDTH - 1));
  assign w_last_row  = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_row_valid = (r_row >= RW'(4));
  assign w_we        = done_i & ~rst;

  // Line buffers share the column address; the read is asynchronous so the old
  // contents are available in the same cycle they are overwritten.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lb
      logic [DATA_WIDTH-1:0] r_mem [IMG_WIDTH];
      logic [DATA_WIDTH-1:0] w_wr;

      if (gi == 0) begin : g_head
        assign w_wr = pixel_i;
      end else begin : g_tail
        assign w_wr = w_lb_rd[gi-1];
      end

      always_ff @(posedge clk) begin
        if (w_we) begin
          r_mem[r_col] <= w_wr;
        end
      end

      assign w_lb_rd[gi] = r_mem[r_col];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_s1         <= '0;
      r_s2         <= '0;
      r_s3         <= '0;
      r_s4         <= '0;
      r_s5         <= '0;
      r_col_o      <= '0;
      r_done       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_frame_done <= 1'b0;
      if (done_i) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        // Rows 0-3 only prime the buffers; stale data from a prior frame never escapes.
        if (w_row_valid) begin
          r_s1         <= w_lb_rd[3];
          r_s2         <= w_lb_rd[2];
          r_s3         <= w_lb_rd[1];
          r_s4         <= w_lb_rd[0];
          r_s5         <= pixel_i;
          r_col_o      <= r_col;
          r_done       <= 1'b1;
          r_frame_done <= w_last_col & w_last_row;
        end
      end
    end
  end

  assign S1           = r_s1;
  assign S2           = r_s2;
  assign S3           = r_s3;
  assign S4           = r_s4;
  assign S5           = r_s5;
  assign col_o        = r_col_o;
  assign done_o       = r_done;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_median5_column_feeder.sv
// Bench for median5_column_feeder on an 8x6 image: table-driven rows plus a
// cycle-stamped scoreboard of expected columns.
module tb_median5_column_feeder;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          done_i = 1'b0;
  logic [DW-1:0] pixel_i = '0;
  logic [DW-1:0] S1, S2, S3, S4, S5;
  logic [2:0]    col_o;
  logic          done_o, frame_done_o;

  median5_column_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .pixel_i(pixel_i),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
    .col_o(col_o), .done_o(done_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              row;
    int              col;
    int              gap;
    logic [4:0][7:0] s;   // s[0] = S1 ... s[4] = S5
    int              col_o;
    bit              fd;
  } vec_t;

  typedef struct {
    longint          due;
    logic [4:0][7:0] s;
    logic [2:0]      col;
    bit              fd;
  } exp_t;

  exp_t            sb[$];
  longint          cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  int              n_done = 0;
  int              n_fd = 0;
  int              mode = 0;   // 0: row*16+col, 1: all 0xFF, 2: all 0x00
  int              m_row = 0;
  int              m_col = 0;
  logic [4:0][7:0] last_s = '0;
  logic [2:0]      last_col = '0;

  function automatic logic [7:0] pix(input int md, input int r, input int c);
    if (md == 1) return 8'hFF;
    if (md == 2) return 8'h00;
    return 8'(r * 16 + c);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic advance();
    if (m_col == IW - 1) begin
      m_col = 0;
      m_row = (m_row == IH - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic drive_pixel(input logic [7:0] v, input bit emit, input exp_t e);
    @(negedge clk);
    done_i  = 1'b1;
    pixel_i = v;
    if (emit) begin
      e.due = cyc + 1;
      sb.push_back(e);
    end
  endtask

  // Pixel at the model's current position; expectation derived from the image pattern.
  task automatic send_pix();
    exp_t e;
    e.due = 0;
    for (int k = 0; k < 5; k++) e.s[k] = pix(mode, m_row - 4 + k, m_col);
    e.col = 3'(m_col);
    e.fd  = (m_row == IH - 1) && (m_col == IW - 1);
    drive_pixel(pix(mode, m_row, m_col), m_row >= 4, e);
    advance();
  endtask

  task automatic send_vec(input vec_t t);
    exp_t e;
    e.due = 0;
    e.s   = t.s;
    e.col = 3'(t.col_o);
    e.fd  = t.fd;
    drive_pixel(pix(mode, t.row, t.col), 1'b1, e);
    advance();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      done_i = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst      = 1'b1;
    done_i   = 1'b1;       // reset must win over a simultaneous pixel
    pixel_i  = 8'hAA;
    last_s   = '0;
    last_col = '0;
    @(negedge clk);
    rst    = 1'b0;
    done_i = 1'b0;
    m_row  = 0;
    m_col  = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: pops one expectation per done_o, otherwise outputs must hold.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done_o) begin
        n_done++;
        chk("expected_column_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("latency_cycle", cyc, e.due);
          chk("S5..S1", {S5, S4, S3, S2, S1}, e.s);
          chk("col_o", col_o, e.col);
          chk("frame_done_o", frame_done_o, e.fd);
          $display("col  cyc=%0d col=%0d S=%h %h %h %h %h fd=%0b", cyc, col_o, S1, S2, S3, S4, S5, frame_done_o);
        end
        last_s   = {S5, S4, S3, S2, S1};
        last_col = col_o;
        if (frame_done_o) n_fd++;
      end else begin
        chk("hold_S", {S5, S4, S3, S2, S1}, last_s);
        chk("hold_col_o", col_o, last_col);
        chk("frame_done_idle", frame_done_o, 0);
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missing_done_o", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  vec_t tbl[16];
  int   base;

  initial begin
    // Rows 4 and 5 of the first frame: row 4 spaced by 3 idle cycles, row 5 back to back.
    for (int i = 0; i < 16; i++) begin
      tbl[i].row   = 4 + i / 8;
      tbl[i].col   = i % 8;
      tbl[i].gap   = (i >= 1 && i < 8) ? 3 : 0;
      for (int k = 0; k < 5; k++) tbl[i].s[k] = 8'(((tbl[i].row - 4 + k) << 4) | tbl[i].col);
      tbl[i].col_o = i % 8;
      tbl[i].fd    = 1'b0;
    end
    tbl[0].s   = {8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
    tbl[15].s  = {8'h57, 8'h47, 8'h37, 8'h27, 8'h17};
    tbl[15].fd = 1'b1;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_done_o", done_o, 0);
    chk("reset_S", {S5, S4, S3, S2, S1}, 0);

    // Rows 0-3 only fill the buffers.
    repeat (4 * IW) send_pix();
    idle(2);
    chk("rows0_3_no_done", n_done, 0);
    chk("rows0_3_no_frame_done", n_fd, 0);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].gap > 0) idle(tbl[i].gap);
      send_vec(tbl[i]);
    end
    idle(2);
    chk("frame1_columns", n_done, 16);
    chk("frame1_frame_done", n_fd, 1);

    // Second frame: no output during rows 0-3, then reset after pixel (4,3).
    repeat (4 * IW) send_pix();
    idle(1);
    chk("frame2_rows0_3_no_done", n_done, 16);
    repeat (4) send_pix();
    idle(2);
    chk("frame2_row4_cols", n_done, 20);
    pulse_reset();
    base = n_done;
    repeat (4 * IW) send_pix();
    idle(2);
    chk("post_reset_32_no_done", n_done, base);
    send_pix();
    idle(2);
    chk("post_reset_33rd_done", n_done, base + 1);
    chk("post_reset_33rd_col", last_col, 0);

    // Finish the frame, then an all-0xFF frame followed by an all-0x00 frame.
    while (!(m_row == 0 && m_col == 0)) send_pix();
    mode = 1;
    repeat (IW * IH) send_pix();
    mode = 2;
    repeat (IW * IH) send_pix();
    idle(3);
    chk("zero_frame_last_column", last_s, 0);
    chk("frame_done_total", n_fd, 4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
